echo_client: RTL and testbench

- Initiator side of the ethertype-0x1234 echo service; the echo responder on the far end swaps MACs and returns the frame unchanged.
- On a start pulse it builds a request frame, rings the mac_tx_ifc doorbell, then waits for the matching reply from mac_rx_ifc.
- It verifies the reply and reports pass, fail or timeout along with the round-trip cycle count.
- Sits at the network top level beside mac_tx_ifc and mac_rx_ifc, sharing their pktbuf/maxaddr/doorbell interface.

---
 rtl/net_pkg.sv | 27 ++
 rtl/echo_client_if.sv | 37 +++
 rtl/echo_client_frame_gen.sv | 32 +++
 rtl/echo_client.sv | 150 +++++++++++++++
 tb/tb_echo_client.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/net_pkg.sv
// Shared Ethernet constants and FSM state type for the echo client.
package net_pkg;

  localparam int ETH_MTU = 1518;

  // Byte offsets inside an Ethernet II frame
  localparam int ETH_DST_OFF     = 0;
  localparam int ETH_SRC_OFF     = 6;
  localparam int ETH_TYPE_OFF    = 12;
  localparam int ETH_PAYLOAD_OFF = 14;

  // Echo service ethertype 0x1234
  localparam logic [7:0] ETHTYPE_HI = 8'h12;
  localparam logic [7:0] ETHTYPE_LO = 8'h34;

  // Our own station address b8:27:eb:a4:30:73, first wire byte in the MSBs
  localparam logic [47:0] MYADDR = 48'hb827eba43073;

  typedef enum logic [2:0] {
    IDLE,
    BUILD,
    SEND,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/echo_client_if.sv
// Packet-buffer / maxaddr / doorbell bundle shared with mac_tx_ifc and mac_rx_ifc.
interface echo_client_if #(
  parameter int ETH_MTU = net_pkg::ETH_MTU
);

  logic       tx_available;
  logic [7:0] tx_pktbuf [ETH_MTU];
  logic [10:0] tx_pktbuf_maxaddr;
  logic       tx_doorbell;

  logic [7:0] rx_pktbuf [ETH_MTU];
  logic [10:0] rx_pktbuf_maxaddr;
  logic       rx_doorbell;

  // Echo client side
  modport master (
    input  tx_available,
    output tx_pktbuf,
    output tx_pktbuf_maxaddr,
    output tx_doorbell,
    input  rx_pktbuf,
    input  rx_pktbuf_maxaddr,
    input  rx_doorbell
  );

  // MAC side
  modport slave (
    output tx_available,
    input  tx_pktbuf,
    input  tx_pktbuf_maxaddr,
    input  tx_doorbell,
    output rx_pktbuf,
    output rx_pktbuf_maxaddr,
    output rx_doorbell
  );

endinterface

// File: rtl/echo_client_frame_gen.sv
// Combinational generator of the full echo request frame for a given seq/peer.
// One copy serves both the tx build and the rx payload compare.
module echo_frame_gen #(
  parameter int ETH_MTU = net_pkg::ETH_MTU,
  parameter int PKT_LEN = 64
) (
  input  logic [7:0]  seq,
  input  logic [47:0] dst_mac,
  output logic [7:0]  frame [ETH_MTU]
);
  import net_pkg::*;

  // Every byte position is a pure function of its index, seq and the peer MAC
  always_comb begin
    for (int i = 0; i < ETH_MTU; i++) begin
      frame[i] = 8'h00;
      if (i < PKT_LEN) begin
        if (i < ETH_SRC_OFF)
          frame[i] = dst_mac[8*(5-i) +: 8];
        else if (i < ETH_TYPE_OFF)
          frame[i] = MYADDR[8*(11-i) +: 8];
        else if (i == ETH_TYPE_OFF)
          frame[i] = ETHTYPE_HI;
        else if (i == ETH_TYPE_OFF + 1)
          frame[i] = ETHTYPE_LO;
        else
          frame[i] = seq + 8'(i - ETH_PAYLOAD_OFF);
      end
    end
  end

endmodule

// File: rtl/echo_client.sv
// Echo service initiator: builds a request, rings the tx doorbell, then
// checks the echoed reply and reports pass/fail/timeout plus round-trip time.
module echo_client #(
  parameter int ETH_MTU        = net_pkg::ETH_MTU,
  parameter int PKT_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int RTT_W          = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [47:0]      dst_mac,
  echo_client_if.master    mac,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [RTT_W-1:0] rtt_cycles,
  output logic [7:0]       seq
);
  import net_pkg::*;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_n;
  logic [47:0]     dst_q;
  logic [TO_W-1:0] tcnt;
  logic            rx_doorbell_q;
  logic [7:0]      gen_frame [ETH_MTU];
  logic            rx_edge, rx_is_echo, rx_match, to_hit, tx_fire;

  function automatic logic [RTT_W-1:0] sat_inc(input logic [RTT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  echo_frame_gen #(
    .ETH_MTU (ETH_MTU),
    .PKT_LEN (PKT_LEN)
  ) u_frame_gen (
    .seq     (seq),
    .dst_mac (dst_q),
    .frame   (gen_frame)
  );

  // Classify the incoming frame; the rx buffer is short-lived so all of this
  // must resolve in the same cycle as the doorbell edge
  always_comb begin
    rx_edge    = mac.rx_doorbell & ~rx_doorbell_q;
    rx_is_echo = (mac.rx_pktbuf[ETH_TYPE_OFF]     == ETHTYPE_HI) &&
                 (mac.rx_pktbuf[ETH_TYPE_OFF + 1] == ETHTYPE_LO) &&
                 ({mac.rx_pktbuf[0], mac.rx_pktbuf[1], mac.rx_pktbuf[2],
                   mac.rx_pktbuf[3], mac.rx_pktbuf[4], mac.rx_pktbuf[5]} == MYADDR);
    rx_match   = ({mac.rx_pktbuf[6], mac.rx_pktbuf[7], mac.rx_pktbuf[8],
                   mac.rx_pktbuf[9], mac.rx_pktbuf[10], mac.rx_pktbuf[11]} == dst_q) &&
                 (mac.rx_pktbuf_maxaddr == 11'(PKT_LEN - 1));
    for (int i = ETH_PAYLOAD_OFF; i < PKT_LEN; i++) begin
      if (mac.rx_pktbuf[i] != gen_frame[i])
        rx_match = 1'b0;
    end
    to_hit  = (tcnt == TO_LAST);
    tx_fire = (state == SEND) && mac.tx_available;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = BUILD;
      BUILD:   state_n = SEND;
      SEND:    if (mac.tx_available) state_n = WAIT;
      WAIT:    if ((rx_edge && rx_is_echo) || to_hit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control flags, sequence number, doorbell and rx edge tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      seq           <= 8'h00;
      mac.tx_doorbell <= 1'b0;
      rx_doorbell_q <= 1'b0;
    end else begin
      rx_doorbell_q   <= mac.rx_doorbell;
      mac.tx_doorbell <= tx_fire;
      case (state)
        IDLE: if (start) begin
          seq     <= seq + 8'd1;
          pass    <= 1'b0;
          fail    <= 1'b0;
          timeout <= 1'b0;
          busy    <= 1'b1;
        end
        WAIT: begin
          // An accepted frame takes priority over a coincident timeout
          if (rx_edge && rx_is_echo) begin
            pass <= rx_match;
            fail <= ~rx_match;
          end else if (to_hit) begin
            timeout <= 1'b1;
          end
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Peer MAC captured with the accepted start, used for build and compare
  always_ff @(posedge clk) begin
    if (state == IDLE && start) dst_q <= dst_mac;
  end

  // Round-trip and timeout counters, restarted when the doorbell fires
  always_ff @(posedge clk) begin
    if (rst) begin
      rtt_cycles <= '0;
      tcnt       <= '0;
    end else if (tx_fire) begin
      rtt_cycles <= '0;
      tcnt       <= '0;
    end else if (state == WAIT) begin
      rtt_cycles <= sat_inc(rtt_cycles);
      if (!to_hit) tcnt <= tcnt + 1'b1;
    end
  end

  // Transmit buffer: whole frame written in BUILD, stable until the next BUILD
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ETH_MTU; i++) mac.tx_pktbuf[i] <= 8'h00;
      mac.tx_pktbuf_maxaddr <= 11'd0;
    end else if (state == BUILD) begin
      for (int i = 0; i < ETH_MTU; i++) mac.tx_pktbuf[i] <= gen_frame[i];
      mac.tx_pktbuf_maxaddr <= 11'(PKT_LEN - 1);
    end
  end

endmodule

// File: tb/tb_echo_client.sv
// Directed bench for echo_client with a loopback responder driven from the
// stimulus sequence (MAC swap, optional corruption or foreign ethertype).
module tb_echo_client;

  localparam int MTU = 1518;

  logic        clk;
  logic        rst;
  logic        start;
  logic [47:0] dst_mac;
  logic        busy, pass, fail, timeout;
  logic [23:0] rtt_cycles;
  logic [7:0]  seq;

  int errors = 0;
  int checks = 0;
  int db_cnt = 0;

  echo_client_if #(.ETH_MTU(MTU)) mac();

  echo_client #(
    .ETH_MTU        (MTU),
    .PKT_LEN        (64),
    .TIMEOUT_CYCLES (1000),
    .RTT_W          (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dst_mac    (dst_mac),
    .mac        (mac),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .rtt_cycles (rtt_cycles),
    .seq        (seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which the doorbell is high
  always @(posedge clk) if (mac.tx_doorbell) db_cnt <= db_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [47:0] mac_addr);
    dst_mac = mac_addr;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_doorbell();
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (mac.tx_doorbell === 1'b1) seen = 1'b1;
    end
    chk("doorbell_seen", 64'(seen), 64'd1);
  endtask

  // Loopback reply: copy tx frame, swap MACs, set ethertype, optionally corrupt one byte
  task automatic make_reply(input int corrupt, input logic [15:0] etype);
    for (int i = 0; i < MTU; i++) mac.rx_pktbuf[i] = mac.tx_pktbuf[i];
    for (int i = 0; i < 6; i++) begin
      mac.rx_pktbuf[i]     = mac.tx_pktbuf[i + 6];
      mac.rx_pktbuf[i + 6] = mac.tx_pktbuf[i];
    end
    mac.rx_pktbuf[12] = etype[15:8];
    mac.rx_pktbuf[13] = etype[7:0];
    if (corrupt >= 0) mac.rx_pktbuf[corrupt] = ~mac.tx_pktbuf[corrupt];
    mac.rx_pktbuf_maxaddr = mac.tx_pktbuf_maxaddr;
  endtask

  task automatic quick_echo(output bit ok);
    pulse_start(48'h0a0b0c0d0e0f);
    wait_doorbell();
    make_reply(-1, 16'h1234);
    mac.rx_doorbell = 1'b1;
    tick();
    ok = pass;
    tick();
    mac.rx_doorbell = 1'b0;
  endtask

  initial begin
    bit any_db, busy_low, ok;
    int npass;

    rst   = 1'b1;
    start = 1'b0;
    dst_mac = 48'h0;
    mac.tx_available = 1'b1;
    mac.rx_doorbell  = 1'b0;
    mac.rx_pktbuf_maxaddr = 11'd0;
    for (int i = 0; i < MTU; i++) mac.rx_pktbuf[i] = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 64'(busy), 0);
    chk("rst_flags", 64'({pass, fail, timeout}), 0);
    chk("rst_seq", 64'(seq), 0);
    chk("rst_rtt", 64'(rtt_cycles), 0);
    chk("rst_doorbell", 64'(mac.tx_doorbell), 0);
    chk("rst_maxaddr", 64'(mac.tx_pktbuf_maxaddr), 0);
    chk("rst_txbyte0", 64'(mac.tx_pktbuf[0]), 0);

    // Txn 1: normal echo, reply raised 10 cycles after the doorbell cycle.
    // rtt: 0 at doorbell, +1 on each of 10 WAIT edges, +1 on the accept edge = 11
    pulse_start(48'h112233445566);
    chk("t1_seq", 64'(seq), 1);
    chk("t1_busy", 64'(busy), 1);
    wait_doorbell();
    chk("t1_b0", 64'(mac.tx_pktbuf[0]), 64'h11);
    chk("t1_b5", 64'(mac.tx_pktbuf[5]), 64'h66);
    chk("t1_b6", 64'(mac.tx_pktbuf[6]), 64'hb8);
    chk("t1_b11", 64'(mac.tx_pktbuf[11]), 64'h73);
    chk("t1_type", 64'({mac.tx_pktbuf[12], mac.tx_pktbuf[13]}), 64'h1234);
    chk("t1_b14", 64'(mac.tx_pktbuf[14]), 64'h01);
    chk("t1_b15", 64'(mac.tx_pktbuf[15]), 64'h02);
    chk("t1_b63", 64'(mac.tx_pktbuf[63]), 64'h32);
    chk("t1_b64", 64'(mac.tx_pktbuf[64]), 64'h00);
    chk("t1_maxaddr", 64'(mac.tx_pktbuf_maxaddr), 63);
    repeat (10) tick();
    make_reply(-1, 16'h1234);
    mac.rx_doorbell = 1'b1;
    tick();
    chk("t1_pass", 64'({pass, fail, timeout}), 64'b100);
    chk("t1_rtt", 64'(rtt_cycles), 11);
    chk("t1_busy_done", 64'(busy), 1);
    tick();
    mac.rx_doorbell = 1'b0;
    chk("t1_busy_idle", 64'(busy), 0);
    chk("t1_one_doorbell", 64'(db_cnt), 1);

    // Txn 2: transmitter unavailable for 200 cycles
    mac.tx_available = 1'b0;
    pulse_start(48'h112233445566);
    chk("t2_pass_cleared", 64'(pass), 0);
    any_db = 1'b0;
    busy_low = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (mac.tx_doorbell !== 1'b0) any_db = 1'b1;
      if (busy !== 1'b1) busy_low = 1'b1;
    end
    chk("t2_no_doorbell", 64'(any_db), 0);
    chk("t2_busy_held", 64'(busy_low), 0);
    mac.tx_available = 1'b1;
    tick();
    chk("t2_doorbell_first_avail", 64'(mac.tx_doorbell), 1);
    repeat (10) tick();
    make_reply(-1, 16'h1234);
    mac.rx_doorbell = 1'b1;
    tick();
    chk("t2_pass", 64'({pass, fail, timeout}), 64'b100);
    chk("t2_seq", 64'(seq), 2);
    tick();
    mac.rx_doorbell = 1'b0;

    // Txn 3: payload byte 30 corrupted
    pulse_start(48'h112233445566);
    wait_doorbell();
    repeat (3) tick();
    make_reply(30, 16'h1234);
    mac.rx_doorbell = 1'b1;
    tick();
    chk("t3_fail", 64'({pass, fail, timeout}), 64'b010);
    chk("t3_busy_done", 64'(busy), 1);
    tick();
    mac.rx_doorbell = 1'b0;
    chk("t3_busy_drop", 64'(busy), 0);

    // Txn 4: ARP frame first is ignored, then valid echo
    pulse_start(48'h112233445566);
    wait_doorbell();
    make_reply(-1, 16'h0806);
    mac.rx_doorbell = 1'b1;
    tick();
    tick();
    chk("t4_arp_ignored", 64'({busy, pass, fail, timeout}), 64'b1000);
    mac.rx_doorbell = 1'b0;
    tick();
    make_reply(-1, 16'h1234);
    mac.rx_doorbell = 1'b1;
    tick();
    chk("t4_pass", 64'({pass, fail, timeout}), 64'b100);
    tick();
    mac.rx_doorbell = 1'b0;

    // Txn 5: rx_doorbell already high (stale seq-4 frame) on entry to WAIT
    mac.rx_doorbell = 1'b1;
    pulse_start(48'h112233445566);
    wait_doorbell();
    repeat (5) tick();
    chk("t5_stale_ignored", 64'({busy, pass, fail}), 64'b100);
    mac.rx_doorbell = 1'b0;
    tick();
    make_reply(-1, 16'h1234);
    mac.rx_doorbell = 1'b1;
    tick();
    chk("t5_pass", 64'({pass, fail, timeout}), 64'b100);
    tick();
    mac.rx_doorbell = 1'b0;

    // Txn 6: no reply, timeout on the 1000th WAIT cycle
    pulse_start(48'h112233445566);
    wait_doorbell();
    repeat (999) tick();
    chk("t6_no_timeout_yet", 64'({busy, timeout}), 64'b10);
    tick();
    chk("t6_timeout", 64'({pass, fail, timeout}), 64'b001);
    chk("t6_rtt", 64'(rtt_cycles), 1000);
    tick();
    chk("t6_busy_drop", 64'(busy), 0);

    // Txn 7: restart clears flags; reply edge coincides with timeout, frame wins
    pulse_start(48'h112233445566);
    chk("t7_seq", 64'(seq), 7);
    chk("t7_cleared", 64'({busy, pass, fail, timeout}), 64'b1000);
    wait_doorbell();
    repeat (999) tick();
    make_reply(-1, 16'h1234);
    mac.rx_doorbell = 1'b1;
    tick();
    chk("t7_frame_wins", 64'({pass, fail, timeout}), 64'b100);
    tick();
    mac.rx_doorbell = 1'b0;

    // 249 more passes take seq from 7 through 255 to 0
    npass = 0;
    for (int n = 0; n < 249; n++) begin
      quick_echo(ok);
      if (ok) npass++;
    end
    chk("wrap_passes", 64'(npass), 249);
    chk("wrap_seq", 64'(seq), 0);
    chk("wrap_doorbells", 64'(db_cnt), 256);

    // Reset during WAIT aborts; start coincident with reset is ignored
    pulse_start(48'h112233445566);
    wait_doorbell();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("wrst_flags", 64'({busy, pass, fail, timeout}), 0);
    chk("wrst_seq", 64'(seq), 0);
    chk("wrst_rtt", 64'(rtt_cycles), 0);
    chk("wrst_txbyte14", 64'(mac.tx_pktbuf[14]), 0);
    chk("wrst_maxaddr", 64'(mac.tx_pktbuf_maxaddr), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_start_ignored", 64'({busy, seq}), 0);
    make_reply(-1, 16'h1234);
    mac.rx_doorbell = 1'b1;
    repeat (50) tick();
    mac.rx_doorbell = 1'b0;
    chk("wrst_no_doorbell", 64'(db_cnt), 257);
    chk("wrst_no_pass", 64'(pass), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
